dbus_responder: RTL and testbench
=================================

// Module: dbus_responder
// PURPOSE
//  Data-bus target on the far side of the pipelined CPU's MEM-stage port: it services mem_addr/mem_data/mem_we
//  and returns mem_data_in in the same cycle. It holds the data RAM plus an MMIO block with a timer and an
//  interrupt controller. That controller drives the CPU's int_[5:0] lines, and software acknowledges via MMIO.
// PARAMETERS
//  RAM_WORDS  1024            data RAM depth in 32-bit words (power of 2); RAM at 0x0000_0000..RAM_WORDS*4-1
//  MMIO_BASE  32'hFFFF_0000   base of MMIO window; offsets 0x00..0x14 decoded, addr[15:5] must be 0
//  SYNC_STG   2               synchronizer flops on ext_irq
// PORTS
//  clk          in   1   single clock; RAM/regs update on rising edge
//  rst          in   1   reset, asynchronous, active-low
//  mem_addr     in   32  byte address from CPU MEM stage; addr[1:0] ignored (word access only)
//  mem_data     in   32  store data
//  mem_we       in   1   store strobe, 1 = write this cycle
//  mem_data_in  out  32  load data to CPU, combinational from mem_addr (CPU samples same cycle)
//  cause_data   in   32  CPU CAUSE register, readable at MMIO+0x14
//  ext_irq      in   4   asynchronous level interrupt requests
//  int_         out  6   registered interrupt lines to CPU (pend & mask)
//  bus_err      out  1   registered 1-cycle pulse: previous access hit an unmapped address
// BEHAVIOUR
//  Reset (rst=0): int_=0, bus_err=0; COUNT=0, CMP=32'hFFFF_FFFF, CTRL=0, PEND=0, MASK=0, sync flops=0.
//  RAM contents are not reset.
//  Decode: RAM when mem_addr < RAM_WORDS*4. MMIO when mem_addr[31:5]==MMIO_BASE[31:5] and offset<=0x14.
//   Anything else is unmapped: reads return 0, writes are dropped, PEND[5] is set and bus_err pulses next cycle.
//  RAM: asynchronous read at mem_addr[log2(RAM_WORDS)+1:2]; write at posedge when mem_we.
//   Read-during-write of the same word returns the old data.
//  MMIO map (offset): 0x00 COUNT rw | 0x04 CMP rw | 0x08 CTRL rw [0]=EN [1]=AUTORELOAD | 0x0C PEND r, W1C [5:0]
//   | 0x10 MASK rw [5:0] | 0x14 CAUSE ro (=cause_data). Unused bits read 0. Writes to ro regs are ignored.
//  Timer: if EN, COUNT<=COUNT+1 each cycle, wrapping 32'hFFFF_FFFF->0.
//   Match when COUNT==CMP and EN: sets PEND[0]. If AUTORELOAD, COUNT<=0 in that cycle instead of +1.
//   A CPU write to COUNT overrides increment/reload in the same cycle.
//  PEND sources: [0] timer match; [4:1] rising edge of ext_irq[3:0] after SYNC_STG flops (level held high = one
//   event); [5] unmapped access.
//  PEND priority: a set event in the same cycle as a W1C of that bit wins (bit stays 1).
//  int_ <= PEND & MASK, so int_ lags the PEND update by exactly 1 cycle.
//  Latency: ext_irq rise -> PEND set after SYNC_STG+1 edges -> int_ one edge later.
//  Reset asserted mid-operation clears all registers immediately. The RAM keeps its contents; the write in
//   progress is lost.
// STRUCTURE
//  Shared package dbus_pkg: MMIO offsets (OFF_COUNT..OFF_CAUSE), CTRL bit indices, PEND bit indices
//   (IRQ_TIMER=0, IRQ_EXT_LO=1, IRQ_BUSERR=5).
//  Sub-module dbus_timer holds COUNT/CMP/CTRL, the write-override logic and the match pulse output.
//  RAM array, decoder, synchronizer, PEND/MASK and the read mux stay in the top.
// TESTING
//  1 RAM: write 0x1234_5678 @0x10, read @0x10 next cycle -> 0x1234_5678; read @0x13 -> same word (addr[1:0] ignored).
//  2 Timer: CMP=5, CTRL=3, MASK=1 -> PEND[0]=1 when COUNT hits 5, int_[0]=1 one cycle later, COUNT wraps to 0.
//    W1C 0x1 to PEND -> int_[0]=0 next cycle.
//  3 Ext IRQ: ext_irq[2] 0->1 and held 50 cycles, MASK=6'h08 -> PEND[3] set once at SYNC_STG+1 edges,
//    int_[3] 1 edge later. After W1C, no re-set while the level stays high.
//  4 Collision: W1C PEND[0] in the exact cycle of a timer match -> PEND[0] stays 1.
//    COUNT write in the match cycle -> COUNT takes the written value.
//  5 Unmapped: read 0x8000_0000 -> mem_data_in=0, bus_err pulses 1 cycle, PEND[5]=1.
//    Write 0xFFFF_0040 -> no register changes.
//  6 Reset: assert rst low while EN=1 and int_!=0 -> int_=0, COUNT=0, MASK=0 immediately.
//    Data written to RAM before reset reads back unchanged after release.

Source files
------------

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared constants, types and address decode for the data-bus responder
package dbus_pkg;

  // MMIO register byte offsets inside the window
  localparam logic [4:0] OFF_COUNT = 5'h00;
  localparam logic [4:0] OFF_CMP   = 5'h04;
  localparam logic [4:0] OFF_CTRL  = 5'h08;
  localparam logic [4:0] OFF_PEND  = 5'h0C;
  localparam logic [4:0] OFF_MASK  = 5'h10;
  localparam logic [4:0] OFF_CAUSE = 5'h14;

  // CTRL bit indices
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;

  // PEND / int_ bit indices
  localparam int IRQ_TIMER  = 0;
  localparam int IRQ_EXT_LO = 1;
  localparam int IRQ_BUSERR = 5;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // Classify a byte address; the low two bits only matter for the RAM bound check
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [26:0] base_hi);
    if (addr < ram_bytes) return REG_RAM;
    if (addr[31:5] == base_hi && {addr[4:2], 2'b00} <= OFF_CAUSE) return REG_MMIO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dbus_timer.sv
// rtl/dbus_timer.sv - free-running compare timer with autoreload and CPU write override
module dbus_timer
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic        wr_ctrl,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [1:0]  ctrl,
  output logic        match
);

  logic [31:0] count_nxt;

  assign match = ctrl[CTRL_EN] && (count == cmp);

  // Next COUNT: a CPU write beats the reload, the reload beats the increment
  always_comb begin
    count_nxt = count;
    if (wr_count)
      count_nxt = wdata;
    else if (match && ctrl[CTRL_AUTO])
      count_nxt = '0;
    else if (ctrl[CTRL_EN])
      count_nxt = count + 32'd1;
  end

  // Timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      cmp   <= '1;
      ctrl  <= '0;
    end else begin
      count <= count_nxt;
      if (wr_cmp)  cmp  <= wdata;
      if (wr_ctrl) ctrl <= wdata[1:0];
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - data RAM plus timer/interrupt MMIO behind the CPU MEM-stage port
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          SYNC_STG  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_we,
  output logic [31:0] mem_data_in,
  input  logic [31:0] cause_data,
  input  logic [3:0]  ext_irq,
  output logic [5:0]  int_,
  output logic        bus_err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   ram [RAM_WORDS];
  region_e       region;
  logic [4:0]    off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          mmio_wr;
  logic          unmapped;

  logic [31:0]   count;
  logic [31:0]   cmp;
  logic [1:0]    ctrl;
  logic          match;

  logic [3:0]    sync [SYNC_STG];
  logic [3:0]    ext_q;
  logic [3:0]    ext_rise;
  logic [5:0]    pend;
  logic [5:0]    mask;
  logic [5:0]    pend_set;
  logic [5:0]    pend_clr;

  assign region   = decode_region(mem_addr, RAM_BYTES, MMIO_BASE[31:5]);
  assign off      = {mem_addr[4:2], 2'b00};
  assign ram_idx  = mem_addr[AW+1:2];
  assign ram_we   = mem_we && (region == REG_RAM);
  assign mmio_wr  = mem_we && (region == REG_MMIO);
  assign unmapped = (region == REG_NONE);

  dbus_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .wr_count (mmio_wr && off == OFF_COUNT),
    .wr_cmp   (mmio_wr && off == OFF_CMP),
    .wr_ctrl  (mmio_wr && off == OFF_CTRL),
    .wdata    (mem_data),
    .count    (count),
    .cmp      (cmp),
    .ctrl     (ctrl),
    .match    (match)
  );

  // RAM store; contents survive reset and a store coinciding with reset is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (ram_we) begin
      ram[ram_idx] <= mem_data;
    end
  end

  // ext_irq synchronizer chain plus one stage of history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STG; i++) sync[i] <= '0;
      ext_q <= '0;
    end else begin
      sync[0] <= ext_irq;
      for (int i = 1; i < SYNC_STG; i++) sync[i] <= sync[i-1];
      ext_q <= sync[SYNC_STG-1];
    end
  end

  assign ext_rise = sync[SYNC_STG-1] & ~ext_q;

  // Gather this cycle's PEND set events and the CPU's write-one-to-clear mask
  always_comb begin
    pend_set = '0;
    pend_set[IRQ_TIMER]                = match;
    pend_set[IRQ_EXT_LO+3:IRQ_EXT_LO]  = ext_rise;
    pend_set[IRQ_BUSERR]               = unmapped;
    pend_clr = (mmio_wr && off == OFF_PEND) ? mem_data[5:0] : 6'd0;
  end

  // PEND/MASK, interrupt lines and bus error pulse; set wins over clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= '0;
      mask    <= '0;
      int_    <= '0;
      bus_err <= 1'b0;
    end else begin
      pend    <= (pend & ~pend_clr) | pend_set;
      if (mmio_wr && off == OFF_MASK) mask <= mem_data[5:0];
      int_    <= pend & mask;
      bus_err <= unmapped;
    end
  end

  // Same-cycle load data; unmapped addresses read as zero
  always_comb begin
    mem_data_in = '0;
    case (region)
      REG_RAM: mem_data_in = ram[ram_idx];
      REG_MMIO: begin
        case (off)
          OFF_COUNT: mem_data_in = count;
          OFF_CMP:   mem_data_in = cmp;
          OFF_CTRL:  mem_data_in = {30'd0, ctrl};
          OFF_PEND:  mem_data_in = {26'd0, pend};
          OFF_MASK:  mem_data_in = {26'd0, mask};
          OFF_CAUSE: mem_data_in = cause_data;
          default:   mem_data_in = '0;
        endcase
      end
      default: mem_data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - randomized self-checking bench for dbus_responder
module tb_dbus_responder;

  localparam int          RW   = 1024;
  localparam logic [31:0] MB   = 32'hFFFF_0000;
  localparam int          SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_data, mem_data_in, cause_data;
  logic        mem_we;
  logic [3:0]  ext_irq;
  logic [5:0]  int_;
  logic        bus_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  dbus_responder #(.RAM_WORDS(RW), .MMIO_BASE(MB), .SYNC_STG(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .mem_data_in (mem_data_in),
    .cause_data  (cause_data),
    .ext_irq     (ext_irq),
    .int_        (int_),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0] m_count, m_cmp;
  logic [1:0]  m_ctrl;
  logic [5:0]  m_pend, m_mask, m_int;
  logic        m_berr;
  logic [3:0]  m_hist[$];
  logic [31:0] m_ram [RW];
  bit          m_ok  [RW];

  bit          s_ram, s_mmio, s_hit;
  int          s_reg;
  logic [5:0]  s_set, s_clr;
  logic [31:0] s_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void mread(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v = 32'h0;
    if (a < 32'(RW * 4)) begin
      known = m_ok[a[11:2]];
      v = m_ram[a[11:2]];
    end else if (a >= MB && a < MB + 32'h18) begin
      case ((a - MB) >> 2)
        0: v = m_count;
        1: v = m_cmp;
        2: v = {30'd0, m_ctrl};
        3: v = {26'd0, m_pend};
        4: v = {26'd0, m_mask};
        default: v = cause_data;
      endcase
    end
  endfunction

  // model: whole-cycle update from the register-map rules
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0;
      m_pend = 0; m_mask = 0; m_int = 0; m_berr = 0;
      m_hist = {};
      for (int i = 0; i <= SYNC; i++) m_hist.push_back(4'h0);
    end else begin
      s_ram  = mem_addr < 32'(RW * 4);
      s_mmio = mem_addr >= MB && mem_addr < MB + 32'h18;
      s_reg  = s_mmio ? int'((mem_addr - MB) >> 2) : -1;
      s_hit  = m_ctrl[0] && m_count == m_cmp;
      s_set  = {!s_ram && !s_mmio, m_hist[SYNC-1] & ~m_hist[SYNC], s_hit};
      s_clr  = (mem_we && s_reg == 3) ? mem_data[5:0] : 6'd0;
      s_cnt  = m_count;
      if (m_ctrl[0]) s_cnt = (s_hit && m_ctrl[1]) ? 32'd0 : m_count + 1;
      if (mem_we && s_reg == 0) s_cnt = mem_data;
      m_int  = m_pend & m_mask;
      m_berr = s_set[5];
      m_pend = (m_pend & ~s_clr) | s_set;
      m_count = s_cnt;
      if (mem_we && s_reg == 1) m_cmp  = mem_data;
      if (mem_we && s_reg == 2) m_ctrl = mem_data[1:0];
      if (mem_we && s_reg == 4) m_mask = mem_data[5:0];
      if (mem_we && s_ram) begin
        m_ram[mem_addr[11:2]] = mem_data;
        m_ok[mem_addr[11:2]]  = 1'b1;
      end
      m_hist.push_front(ext_irq);
      void'(m_hist.pop_back());
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [31:0] v;
    bit k;
    if (chk_en) begin
      chk("int_", {26'd0, int_}, {26'd0, m_int});
      chk("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
      mread(mem_addr, v, k);
      if (k) chk("mem_data_in", mem_data_in, v);
    end
  end

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic we);
    mem_addr = a; mem_data = d; mem_we = we;
  endtask

  task automatic adv();
    @(posedge clk); #2;
  endtask

  task automatic look(input logic [31:0] a, output logic [31:0] v);
    mem_addr = a; mem_we = 1'b0; #1; v = mem_data_in;
  endtask

  initial begin
    logic [31:0] v;
    int r, g;
    rst = 1'b0; ext_irq = 4'h0; cause_data = 32'h0000_0A5C;
    put(32'h0, 32'h0, 1'b0);
    for (int i = 0; i < RW; i++) m_ok[i] = 1'b0;
    adv(); chk_en = 1'b1;
    adv();
    chk("rst_int", {26'd0, int_}, 32'h0);
    chk("rst_berr", {31'd0, bus_err}, 32'h0);
    look(MB + 4, v); chk("rst_cmp", v, 32'hFFFF_FFFF);
    rst = 1'b1; adv();

    // RAM write/read, addr[1:0] ignored, read-during-write returns old word
    put(32'h10, 32'h1234_5678, 1'b1); adv();
    look(32'h10, v); chk("t1_read", v, 32'h1234_5678); adv();
    look(32'h13, v); chk("t1_lsb", v, 32'h1234_5678); adv();
    put(32'h10, 32'hA5A5_0001, 1'b1); #1; chk("t1_rdw", mem_data_in, 32'h1234_5678); adv();
    look(32'h10, v); chk("t1_new", v, 32'hA5A5_0001); adv();

    // timer autoreload match
    put(MB + 12, 32'h3F, 1'b1); adv();
    put(MB + 0, 0, 1'b1); adv();
    put(MB + 4, 5, 1'b1); adv();
    put(MB + 16, 1, 1'b1); adv();
    put(MB + 8, 3, 1'b1); adv();
    for (int k = 0; k < 6; k++) begin look(MB + 0, v); chk("t2_count", v, k); adv(); end
    look(MB + 0, v); chk("t2_reload", v, 0);
    look(MB + 12, v); chk("t2_pend0", {31'd0, v[0]}, 1);
    chk("t2_model_pend", {31'd0, m_pend[0]}, 1);
    chk("t2_int_lag", {31'd0, int_[0]}, 0);
    adv(); chk("t2_int0", {31'd0, int_[0]}, 1);
    put(MB + 12, 1, 1'b1); adv(); adv();
    chk("t2_int_clr", {31'd0, int_[0]}, 0);
    put(MB + 8, 0, 1'b1); adv();

    // external interrupt edge through the synchronizer
    put(MB + 16, 8, 1'b1); adv();
    put(MB + 12, 32'h3F, 1'b1); adv();
    put(MB + 12, 0, 1'b0); ext_irq = 4'b0100; adv();
    adv();
    look(MB + 12, v); chk("t3_pend_early", {31'd0, v[3]}, 0); adv();
    look(MB + 12, v); chk("t3_pend_set", {31'd0, v[3]}, 1);
    chk("t3_int_lag", {31'd0, int_[3]}, 0); adv();
    chk("t3_int", {31'd0, int_[3]}, 1);
    put(MB + 12, 8, 1'b1); adv();
    put(MB + 12, 0, 1'b0);
    repeat (45) adv();
    look(MB + 12, v); chk("t3_no_reset", {31'd0, v[3]}, 0);
    chk("t3_int_off", {31'd0, int_[3]}, 0);
    ext_irq = 4'h0; adv();

    // collisions: set beats W1C, COUNT write beats reload
    put(MB + 0, 0, 1'b1); adv();
    put(MB + 4, 3, 1'b1); adv();
    put(MB + 12, 32'h3F, 1'b1); adv();
    put(MB + 8, 1, 1'b1); adv();
    put(MB + 12, 0, 1'b0); adv(); adv(); adv();
    put(MB + 12, 1, 1'b1); adv();
    look(MB + 12, v); chk("t4_set_wins", {31'd0, v[0]}, 1); adv();
    put(MB + 8, 0, 1'b1); adv();
    put(MB + 4, 10, 1'b1); adv();
    put(MB + 0, 10, 1'b1); adv();
    put(MB + 8, 3, 1'b1); adv();
    put(MB + 0, 100, 1'b1); adv();
    look(MB + 0, v); chk("t4_count_wr", v, 100);
    look(MB + 12, v); chk("t4_match_pend", {31'd0, v[0]}, 1); adv();
    put(MB + 8, 0, 1'b1); adv();

    // unmapped accesses
    put(MB + 12, 32'h3F, 1'b1); adv();
    put(32'h8000_0000, 0, 1'b0); #1; chk("t5_rd0", mem_data_in, 0); adv();
    chk("t5_berr", {31'd0, bus_err}, 1);
    look(MB + 12, v); chk("t5_pend5", {31'd0, v[5]}, 1); adv();
    chk("t5_berr_pulse", {31'd0, bus_err}, 0);
    put(32'hFFFF_0040, 32'hFFFF_FFFF, 1'b1); adv();
    look(MB + 16, v); chk("t5_mask", v, 8);
    look(MB + 4, v); chk("t5_cmp", v, 10); adv();
    look(MB + 8, v); chk("t5_ctrl", v, 0); adv();

    // reset mid-operation
    put(32'h40, 32'hCAFE_BABE, 1'b1); adv();
    put(MB + 16, 32'h3F, 1'b1); adv();
    put(MB + 8, 1, 1'b1); adv();
    put(MB + 0, 0, 1'b0); adv();
    chk("t6_int_pre", {31'd0, int_ != 6'd0}, 1);
    put(32'h40, 32'hDEAD_0000, 1'b1); rst = 1'b0; #1;
    chk("t6_int", {26'd0, int_}, 0);
    chk("t6_berr", {31'd0, bus_err}, 0); adv();
    look(MB + 0, v); chk("t6_count", v, 0);
    look(MB + 16, v); chk("t6_mask", v, 0);
    rst = 1'b1; adv();
    look(32'h40, v); chk("t6_ram_kept", v, 32'hCAFE_BABE); adv();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        put($urandom_range(0, 31) * 4 + $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
      end else if (r < 80) begin
        g = $urandom_range(0, 5);
        case (g)
          0, 1:    v = $urandom_range(0, 30);
          2:       v = $urandom_range(0, 3);
          default: v = $urandom;
        endcase
        put(MB + 32'(g * 4) + $urandom_range(0, 3), v, 1'($urandom_range(0, 9) < 4));
      end else if (r < 85) begin
        case ($urandom_range(0, 4))
          0: v = 32'h8000_0000;
          1: v = 32'hFFFF_0018;
          2: v = 32'hFFFF_0020;
          3: v = 32'h0000_1000;
          default: v = 32'hFFFF_0040;
        endcase
        put(v, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        put(32'h0, 0, 1'b0);
      end
      if ($urandom_range(0, 15) == 0) ext_irq = ext_irq ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) cause_data = $urandom;
      adv();
    end

    put(32'h0, 0, 1'b0); adv();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
